// File: rtl/fixed_point_vec_mul_pkg.sv
// Shared types and saturation limits for the fixed-point vector multiplier.
// Optional rounding is selected with FIXED_POINT_VEC_MUL_ROUND_EN in fixed_point_mul.
package fixed_point_vec_mul_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULTIPLY = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fixed_point_mul.sv
// Registered signed fixed-point multiply, shift, optional round and saturate.
// Define FIXED_POINT_VEC_MUL_ROUND_EN to add half an LSB before the shift.
module fixed_point_mul
    import fixed_point_vec_mul_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] prod,
    output logic             ovf,
    output logic             out_valid
);

    // One guard bit above the full product keeps the rounding add from wrapping.
    localparam int PW = 2 * WIDTH + 1;
    localparam logic signed [PW-1:0] SAT_HI = PW'(sat_max(WIDTH));
    localparam logic signed [PW-1:0] SAT_LO = PW'(sat_min(WIDTH));

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] full;
    logic signed [PW-1:0] biased;
    logic signed [PW-1:0] shifted;
    logic [WIDTH-1:0]     sat_val;
    logic                 sat_hit;

`ifdef FIXED_POINT_VEC_MUL_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'((64'sd1 <<< FRAC_BITS) >>> 1);
`endif

    always_comb begin
        a_ext   = {{(WIDTH + 1){a[WIDTH-1]}}, a};
        b_ext   = {{(WIDTH + 1){b[WIDTH-1]}}, b};
        full    = a_ext * b_ext;
`ifdef FIXED_POINT_VEC_MUL_ROUND_EN
        biased  = full + RND;
`else
        biased  = full;
`endif
        shifted = biased >>> FRAC_BITS;
        sat_hit = 1'b0;
        sat_val = shifted[WIDTH-1:0];
        if (shifted > SAT_HI) begin
            sat_val = SAT_HI[WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (shifted < SAT_LO) begin
            sat_val = SAT_LO[WIDTH-1:0];
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prod      <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                prod <= sat_val;
                ovf  <= sat_hit;
            end
        end
    end

endmodule

// File: rtl/fixed_point_vec_mul.sv
// Element-wise fixed-point vector multiplier sharing one registered multiplier.
// Rounding mode follows FIXED_POINT_VEC_MUL_ROUND_EN (see fixed_point_mul).
//
// state    | meaning
// IDLE     | ready; accepts a request and latches both vectors
// MULTIPLY | issues element[index] to the multiplier each cycle
// DRAIN    | waits for the last product to land, then pulses VALID_OUT
module fixed_point_vec_mul
    import fixed_point_vec_mul_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FRAC_BITS  = 5,
    parameter int NUM_INPUTS = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_INPUTS*WIDTH-1:0] VALUES_A_IN,
    input  logic [NUM_INPUTS*WIDTH-1:0] VALUES_B_IN,
    input  logic                        VALID_IN,
    output logic                        READY_OUT,
    output logic [NUM_INPUTS*WIDTH-1:0] VALUES_OUT,
    output logic                        VALID_OUT,
    output logic                        OVERFLOW
);

    localparam int VEC_W = NUM_INPUTS * WIDTH;
    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_INPUTS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] mul_idx;
    logic [VEC_W-1:0] a_q;
    logic [VEC_W-1:0] b_q;
    logic [VEC_W-1:0] values_q;
    logic             valid_q;
    logic             ovf_q;
    logic             done_pend;

    logic             issue;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] mul_prod;
    logic             mul_ovf;
    logic             mul_valid;

    assign issue      = (state == MULTIPLY);
    assign a_sel      = a_q[idx*WIDTH +: WIDTH];
    assign b_sel      = b_q[idx*WIDTH +: WIDTH];
    assign READY_OUT  = (state == IDLE);
    assign VALUES_OUT = values_q;
    assign VALID_OUT  = valid_q;
    assign OVERFLOW   = ovf_q;

    fixed_point_mul #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_mul (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (issue),
        .a         (a_sel),
        .b         (b_sel),
        .prod      (mul_prod),
        .ovf       (mul_ovf),
        .out_valid (mul_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= '0;
            mul_idx   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            values_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            done_pend <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            // Writeback of the product issued one cycle earlier.
            if (mul_valid) begin
                values_q[mul_idx*WIDTH +: WIDTH] <= mul_prod;
                if (mul_ovf) ovf_q <= 1'b1;
                if (mul_idx == LAST) done_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (VALID_IN) begin
                        a_q   <= VALUES_A_IN;
                        b_q   <= VALUES_B_IN;
                        idx   <= '0;
                        ovf_q <= 1'b0;
                        state <= MULTIPLY;
                    end
                end
                MULTIPLY: begin
                    mul_idx <= idx;
                    idx     <= idx + 1'b1;
                    if (idx == LAST) state <= DRAIN;
                end
                DRAIN: begin
                    if (done_pend) begin
                        done_pend <= 1'b0;
                        valid_q   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_vec_mul.sv
// Scoreboard bench for fixed_point_vec_mul; expected vectors come from an integer model.
// Build with FIXED_POINT_VEC_MUL_ROUND_EN to check the rounding variant.
module tb_fixed_point_vec_mul;

    localparam int W   = 8;
    localparam int F   = 5;
    localparam int N   = 16;
    localparam int VW  = N * W;
    localparam int LAT = N + 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [VW-1:0] VALUES_A_IN = '0;
    logic [VW-1:0] VALUES_B_IN = '0;
    logic          VALID_IN = 1'b0;
    logic          READY_OUT;
    logic [VW-1:0] VALUES_OUT;
    logic          VALID_OUT;
    logic          OVERFLOW;

    typedef struct {
        logic [VW-1:0] vals;
        logic          ovf;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    fixed_point_vec_mul #(.WIDTH(W), .FRAC_BITS(F), .NUM_INPUTS(N)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .VALUES_A_IN (VALUES_A_IN),
        .VALUES_B_IN (VALUES_B_IN),
        .VALID_IN    (VALID_IN),
        .READY_OUT   (READY_OUT),
        .VALUES_OUT  (VALUES_OUT),
        .VALID_OUT   (VALID_OUT),
        .OVERFLOW    (OVERFLOW)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                            output logic ovf);
        logic [VW-1:0] v;
        int p;
        int r;
        v   = '0;
        ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            p = $signed(a[i*W +: W]) * $signed(b[i*W +: W]);
`ifdef FIXED_POINT_VEC_MUL_ROUND_EN
            if (F > 0) p = p + (1 << (F - 1));
`endif
            r = p >>> F;
            if (r > 127) begin r = 127; ovf = 1'b1; end
            if (r < -128) begin r = -128; ovf = 1'b1; end
            v[i*W +: W] = r[W-1:0];
        end
        return v;
    endfunction

    // Accept and result monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (VALID_OUT) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("values", VALUES_OUT, e.vals);
                check("overflow", OVERFLOW, e.ovf);
                check("latency", cyc - e.acc, LAT);
            end
        end
        if (!RST && VALID_IN && READY_OUT) begin
            e.vals = model(VALUES_A_IN, VALUES_B_IN, e.ovf);
            e.acc  = cyc + 1;
            sb.push_back(e);
        end
    end

    task automatic drive(input logic [VW-1:0] a, input logic [VW-1:0] b);
        @(posedge CLK); #1;
        VALUES_A_IN = a;
        VALUES_B_IN = b;
        VALID_IN    = 1'b1;
        @(posedge CLK); #1;
        VALID_IN    = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge CLK); #1;
        end
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge CLK);
    endtask

    function automatic logic [VW-1:0] fill(input logic [W-1:0] x);
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = x;
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom_range(0, 255));
        return v;
    endfunction

    initial begin
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [VW-1:0] want;
        bit got;

        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_ready", READY_OUT, 1);
        check("rst_values", VALUES_OUT, 0);
        check("rst_valid", VALID_OUT, 0);
        check("rst_ovf", OVERFLOW, 0);

        // 1.0 x 1.5 everywhere
        drive(fill(8'h20), fill(8'h30));
        wait_done();
        check("unity_slots", VALUES_OUT, fill(8'h30));

        // 1.5 x -2.0 in slot 0 only
        a = '0; b = '0;
        a[0 +: W] = 8'h30; b[0 +: W] = 8'hC0;
        drive(a, b);
        wait_done();
        want = '0; want[0 +: W] = 8'hA0;
        check("neg_slot0", VALUES_OUT, want);

        // positive and negative saturation
        a = '0; b = '0;
        a[3*W +: W] = 8'h60; b[3*W +: W] = 8'h60;
        a[5*W +: W] = 8'h80; b[5*W +: W] = 8'h60;
        drive(a, b);
        wait_done();
        want = '0; want[3*W +: W] = 8'h7F; want[5*W +: W] = 8'h80;
        check("sat_slots", VALUES_OUT, want);
        check("sat_ovf", OVERFLOW, 1);

        // clean request clears the sticky flag
        drive(fill(8'h10), fill(8'h10));
        wait_done();
        check("ovf_cleared", OVERFLOW, 0);

        // rounding boundary
        a = '0; b = '0;
        a[0 +: W] = 8'h10; b[0 +: W] = 8'h01;
        a[W +: W] = 8'hFF; b[W +: W] = 8'h10;
        drive(a, b);
        wait_done();
        want = '0;
`ifdef FIXED_POINT_VEC_MUL_ROUND_EN
        want[0 +: W] = 8'h01; want[W +: W] = 8'h00;
`else
        want[0 +: W] = 8'h00; want[W +: W] = 8'hFF;
`endif
        check("round_slots", VALUES_OUT, want);

        // VALID_IN at acceptance+5 is ignored
        drive(fill(8'h20), fill(8'h28));
        repeat (3) @(posedge CLK);
        drive(fill(8'h7F), fill(8'h7F));
        wait_done();
        check("ignored_req", VALUES_OUT, fill(8'h28));
        check("ignored_ovf", OVERFLOW, 0);

        // back-to-back: new request in the VALID_OUT cycle
        drive(rand_vec(), rand_vec());
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge CLK); #1;
            got = VALID_OUT;
        end
        check("b2b_valid_seen", got, 1);
        VALUES_A_IN = rand_vec();
        VALUES_B_IN = rand_vec();
        VALID_IN    = 1'b1;
        check("b2b_ready", READY_OUT, 1);
        @(posedge CLK); #1;
        VALID_IN = 1'b0;
        wait_done();

        // random traffic
        for (int k = 0; k < 4; k++) begin
            drive(rand_vec(), rand_vec());
            wait_done();
        end

        // reset at acceptance+8 aborts the vector
        drive(fill(8'h60), fill(8'h60));
        repeat (7) @(posedge CLK);
        #1 RST = 1'b1;
        sb.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        check("abort_values", VALUES_OUT, 0);
        check("abort_valid", VALID_OUT, 0);
        check("abort_ovf", OVERFLOW, 0);
        check("abort_ready", READY_OUT, 1);
        repeat (30) @(posedge CLK);
        check("abort_no_pending", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout obs=%0d exp=0", cyc);
        $fatal(1, "global timeout");
    end

endmodule
